// File: rtl/multicycle_seq_if.sv
// multicycle_seq_if: control, imem and status bundle of the multi-cycle sequencer
interface multicycle_seq_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
);
  logic             start;
  logic             halt_req;
  logic             imem_req;
  logic [PC_W-1:0]  imem_addr;
  logic             imem_ack;
  logic [31:0]      imem_rdata;
  logic [31:0]      ir;
  logic             alu_en;
  logic             rf_we;
  logic [PC_W-1:0]  pc;
  logic             busy;
  logic             halted;
  logic             illegal;
  logic             bus_err;
  logic [CNT_W-1:0] retire_cnt;
  logic [2:0]       state;
  modport master (
    input  start, halt_req, imem_ack, imem_rdata,
    output imem_req, imem_addr, ir, alu_en, rf_we, pc, busy, halted,
           illegal, bus_err, retire_cnt, state
  );
  modport slave (
    output start, halt_req, imem_ack, imem_rdata,
    input  imem_req, imem_addr, ir, alu_en, rf_we, pc, busy, halted,
           illegal, bus_err, retire_cnt, state
  );
endinterface

// File: rtl/multicycle_seq.sv
// multicycle_seq: FETCH/DECODE/EXEC/WB sequencer with imem fetch timeout and sticky halt request
module multicycle_seq #(
  parameter int              PC_W          = 32,
  parameter logic [PC_W-1:0] RESET_PC      = '0,
  parameter int              FETCH_TIMEOUT = 16,
  parameter int              CNT_W         = 32
) (
  input logic              clk,
  input logic              rst,
  multicycle_seq_if.master bus
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, HALT, ERROR} state_t;
  localparam int TW = $clog2(FETCH_TIMEOUT + 1);
  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q;
  logic [31:0]      ir_q;
  logic [CNT_W-1:0] cnt_q;
  logic [TW-1:0]    tmo_q;
  logic             hp_q, req_q, alu_q, we_q, busy_q, halted_q, ill_q, berr_q;
  logic             ecall, legal, tmo_hit, fetched, restart;
  always_comb begin
    ecall   = ir_q == 32'h0000_0073;
    legal   = ir_q[6:0] inside {7'b0110011, 7'b0010011, 7'b0110111};
    tmo_hit = tmo_q == TW'(FETCH_TIMEOUT - 1);
    fetched = state_q == FETCH && bus.imem_ack;
    restart = state_q == ERROR && bus.start;
    state_d = state_q;
    case (state_q)
      IDLE, HALT, ERROR: state_d = bus.start ? FETCH : state_q;
      FETCH:             state_d = bus.imem_ack ? DECODE : tmo_hit ? ERROR : FETCH;
      DECODE:            state_d = ecall ? HALT : legal ? EXEC : ERROR;
      EXEC:              state_d = WB;
      WB:                state_d = (hp_q || bus.halt_req) ? HALT : FETCH;
      default:           state_d = IDLE;
    endcase
  end
  // Strobes and status flags are registered from the next state so every output is a flop.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      hp_q     <= 1'b0;
      req_q    <= 1'b0;
      alu_q    <= 1'b0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      ill_q    <= 1'b0;
      berr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= state_d == FETCH;
      alu_q    <= state_d == EXEC;
      we_q     <= state_d == WB;
      busy_q   <= state_d inside {FETCH, DECODE, EXEC, WB};
      halted_q <= state_d == HALT;
      tmo_q    <= (state_q == FETCH && !bus.imem_ack) ? tmo_q + 1'b1 : '0;
      hp_q     <= state_d == HALT ? 1'b0 : hp_q | (busy_q & bus.halt_req);
      if (fetched) ir_q <= bus.imem_rdata;
      pc_q     <= restart ? RESET_PC : state_q == WB ? pc_q + PC_W'(4) : pc_q;
      cnt_q    <= restart ? '0 : state_q == WB ? cnt_q + 1'b1 : cnt_q;
      ill_q    <= restart ? 1'b0 : (state_q == DECODE && state_d == ERROR) | ill_q;
      berr_q   <= restart ? 1'b0 : (state_q == FETCH && state_d == ERROR) | berr_q;
    end
  assign bus.imem_req   = req_q;
  assign bus.imem_addr  = pc_q;
  assign bus.ir         = ir_q;
  assign bus.alu_en     = alu_q;
  assign bus.rf_we      = we_q;
  assign bus.pc         = pc_q;
  assign bus.busy       = busy_q;
  assign bus.halted     = halted_q;
  assign bus.illegal    = ill_q;
  assign bus.bus_err    = berr_q;
  assign bus.retire_cnt = cnt_q;
  assign bus.state      = state_q;
endmodule

// File: tb/tb_multicycle_seq.sv
// tb_multicycle_seq: directed self-checking bench for multicycle_seq
module tb_multicycle_seq;
  localparam logic [31:0] ADDI  = 32'h0010_0093;
  localparam logic [31:0] ADD   = 32'h0020_81B3;
  localparam logic [31:0] LUI   = 32'h1234_5237;
  localparam logic [31:0] ECALL = 32'h0000_0073;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0, errors = 0;
  int cyc = 0, alu_cnt = 0, rf_cnt = 0, both_cnt = 0;
  int c0, a0, r0;
  multicycle_seq_if m ();
  multicycle_seq_if #(.PC_W(8), .CNT_W(4)) s ();
  multicycle_seq dut (.clk(clk), .rst(rst), .bus(m));
  multicycle_seq #(.PC_W(8), .RESET_PC(8'hFC), .CNT_W(4)) dut8 (.clk(clk), .rst(rst), .bus(s));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (m.alu_en) alu_cnt <= alu_cnt + 1;
    if (m.rf_we) rf_cnt <= rf_cnt + 1;
    if (m.alu_en && m.rf_we) both_cnt <= both_cnt + 1;
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic fetch(input logic [31:0] w, input int waits);
    m.imem_ack = 1'b0;
    repeat (waits) tick;
    m.imem_ack = 1'b1;
    m.imem_rdata = w;
    tick;
    m.imem_ack = 1'b0;
  endtask
  initial begin
    m.start = 0; m.halt_req = 0; m.imem_ack = 0; m.imem_rdata = '0;
    s.start = 0; s.halt_req = 0; s.imem_ack = 0; s.imem_rdata = '0;
    repeat (2) tick;
    chk("rst_state", m.state, 0);
    chk("rst_pc", m.pc, 0);
    chk("rst_ir", m.ir, 0);
    chk("rst_cnt", m.retire_cnt, 0);
    chk("rst_flags", {m.imem_req, m.alu_en, m.rf_we, m.busy, m.halted, m.illegal, m.bus_err}, 0);
    chk("rst_pc8", s.pc, 8'hFC);
    rst = 0;
    m.start = 1; tick; m.start = 0;
    chk("t1_fetch", {m.state, m.imem_req, m.busy}, {3'd1, 2'b11});
    chk("t1_addr", m.imem_addr, 0);
    m.imem_ack = 1; m.imem_rdata = ADDI; tick; m.imem_ack = 0;
    chk("t1_decode", m.state, 2);
    chk("t1_ir", m.ir, ADDI);
    tick;
    chk("t1_exec", {m.state, m.alu_en, m.rf_we}, {3'd3, 2'b10});
    tick;
    chk("t1_wb", {m.state, m.alu_en, m.rf_we}, {3'd4, 2'b01});
    chk("t1_wb_pc", m.pc, 0);
    tick;
    chk("t1_next", {m.state, m.rf_we}, {3'd1, 1'b0});
    chk("t1_pc", m.pc, 4);
    chk("t1_cnt", m.retire_cnt, 1);
    rst = 1; tick; rst = 0;
    m.start = 1; tick; m.start = 0;
    a0 = alu_cnt; r0 = rf_cnt;
    c0 = cyc; fetch(ADD, 2); repeat (3) tick;
    chk("t2_add_cyc", cyc - c0, 6);
    chk("t2_add_pc", {m.state, m.pc}, {3'd1, 32'h4});
    c0 = cyc; fetch(LUI, 2); repeat (3) tick;
    chk("t2_lui_cyc", cyc - c0, 6);
    chk("t2_lui_pc", {m.state, m.pc}, {3'd1, 32'h8});
    fetch(ADDI, 2); repeat (3) tick;
    chk("t2_addi_pc", m.pc, 32'hC);
    fetch(ECALL, 2); tick;
    chk("t2_halt", {m.state, m.halted, m.busy}, {3'd5, 2'b10});
    chk("t2_pc", m.pc, 32'hC);
    chk("t2_cnt", m.retire_cnt, 3);
    chk("t2_rf_pulses", rf_cnt - r0, 3);
    chk("t2_alu_pulses", alu_cnt - a0, 3);
    m.start = 1; tick; m.start = 0;
    a0 = alu_cnt; r0 = rf_cnt;
    fetch(32'h0000_0003, 0); tick;
    chk("t3_err", {m.state, m.illegal, m.busy}, {3'd6, 2'b10});
    chk("t3_no_strobes", {alu_cnt - a0, rf_cnt - r0}, 0);
    m.start = 1; tick; m.start = 0;
    chk("t3_restart", {m.state, m.illegal}, {3'd1, 1'b0});
    chk("t3_pc_cnt", {m.pc, m.retire_cnt}, 0);
    repeat (15) tick;
    chk("t4_wait15", {m.state, m.bus_err}, {3'd1, 1'b0});
    tick;
    chk("t4_timeout", {m.state, m.bus_err, m.imem_req}, {3'd6, 2'b10});
    m.imem_ack = 1; m.imem_rdata = 32'hDEAD_BEEF; tick; m.imem_ack = 0;
    chk("t4_ack_ignored", m.ir, 32'h0000_0003);
    m.start = 1; tick; m.start = 0;
    chk("t4_clear", {m.state, m.bus_err}, {3'd1, 1'b0});
    repeat (15) tick;
    m.imem_ack = 1; m.imem_rdata = ADDI; tick; m.imem_ack = 0;
    chk("t4_ack16", {m.state, m.bus_err}, {3'd2, 1'b0});
    tick;
    chk("t5_exec", m.state, 3);
    m.halt_req = 1; tick; m.halt_req = 0;
    chk("t5_wb", {m.state, m.rf_we}, {3'd4, 1'b1});
    tick;
    chk("t5_halt", {m.state, m.halted}, {3'd5, 1'b1});
    chk("t5_pc_cnt", {m.pc, m.retire_cnt}, {32'h4, 32'h1});
    m.start = 1; tick; m.start = 0;
    chk("t5_resume", {m.state, m.imem_addr}, {3'd1, 32'h4});
    m.halt_req = 1; tick; m.halt_req = 0;
    fetch(ADDI, 0); repeat (3) tick;
    chk("t5_fetch_halt", {m.state, m.pc, m.retire_cnt}, {3'd5, 32'h8, 32'h2});
    m.start = 1; tick; m.start = 0;
    fetch(ADDI, 0); tick;
    chk("t6_exec", {m.state, m.alu_en}, {3'd3, 1'b1});
    r0 = rf_cnt;
    #2 rst = 1;
    #1;
    chk("t6_async_state", {m.state, m.alu_en, m.busy, m.imem_req}, 0);
    chk("t6_async_pc", {m.pc, m.retire_cnt}, 0);
    repeat (2) tick;
    rst = 0;
    repeat (2) tick;
    chk("t6_no_rf_we", rf_cnt - r0, 0);
    chk("t6_idle", m.state, 0);
    s.start = 1; tick; s.start = 0;
    chk("t7_addr", s.imem_addr, 8'hFC);
    s.imem_ack = 1; s.imem_rdata = ADDI; tick; s.imem_ack = 0;
    repeat (3) tick;
    chk("t7_wrap", {s.state, s.pc, s.retire_cnt}, {3'd1, 8'h00, 4'd1});
    chk("never_both", both_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_seq.md
Name: multicycle_seq

Overview:
- Multi-cycle sequencer for the RV32 integer core.
- Fetches instructions over a req/ack instruction-memory port and holds each one in an instruction register (IR) that feeds the opcode decoder and ALU.
- Steps every instruction through FETCH/DECODE/EXEC/WB and issues one-cycle ALU-enable and register-file write strobes.
- Supports R-type, I-type ALU and LUI. Detects ECALL, illegal opcodes and fetch timeouts.

Parameters:
PC_W, 32, width of program counter and imem address
RESET_PC, 0, PC value after reset and after restart
FETCH_TIMEOUT, 16, max FETCH cycles without imem_ack before bus error (>=1)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  pulse: leave IDLE/HALT/ERROR and begin fetching
halt_req  in  1  request a stop after the current instruction
imem_req  out  1  fetch request
imem_addr  out  PC_W  fetch address, equals pc
imem_ack  in  1  fetch data valid; meaningful only while imem_req=1
imem_rdata  in  32  instruction word
ir  out  32  latched instruction register
alu_en  out  1  one-cycle ALU operate strobe
rf_we  out  1  one-cycle register-file write strobe
pc  out  PC_W  current program counter
busy  out  1  high in FETCH/DECODE/EXEC/WB
halted  out  1  high in HALT
illegal  out  1  sticky: illegal opcode seen
bus_err  out  1  sticky: fetch timeout
retire_cnt  out  CNT_W  count of retired instructions
state  out  3  debug encoding: IDLE=0 FETCH=1 DECODE=2 EXEC=3 WB=4 HALT=5 ERROR=6

Behaviour:
- Reset, asynchronous and independent of clk: state=IDLE, pc=RESET_PC, ir=0, retire_cnt=0, all single-bit outputs 0, timeout counter 0, halt-pending flag 0.
- Reset mid-instruction abandons the instruction. No rf_we is issued and pc is not updated.
- IDLE: start=1 -> FETCH. halt_req is ignored.
- FETCH: imem_req=1, imem_addr=pc.
  - On imem_ack=1: ir<=imem_rdata, go to DECODE, clear timeout counter.
  - Otherwise the timeout counter increments. When FETCH_TIMEOUT consecutive cycles have passed without ack: bus_err<=1 -> ERROR, imem_req drops the next cycle.
  - An ack arriving in the same cycle as the final timeout count takes priority (fetch succeeds).
- DECODE, one cycle:
  - ir==32'h00000073 (ECALL) -> HALT; not retired, pc unchanged.
  - ir[6:0] in {0110011, 0010011, 0110111} -> EXEC.
  - Any other value -> ERROR with illegal<=1.
- EXEC, one cycle: alu_en=1 -> WB.
- WB, one cycle:
  - rf_we=1. Asserted for every legal instruction including rd=x0; the register file discards x0 writes.
  - pc<=pc+4, wrapping modulo 2^PC_W.
  - retire_cnt<=retire_cnt+1, wrapping modulo 2^CNT_W.
  - Next state: HALT if halt-pending or halt_req=1 this cycle, else FETCH.
- halt_req:
  - Sampled in every busy state and sets a sticky halt-pending flag.
  - The flag is honoured only at the end of WB, so an in-flight instruction always completes.
  - The flag is cleared on entering HALT.
  - halt_req during FETCH wait still completes the fetch and the instruction.
- HALT: halted=1. start=1 -> FETCH, continuing at the current pc; counters are kept.
- ERROR: illegal/bus_err held. start=1 clears both flags, sets pc<=RESET_PC and retire_cnt<=0, then -> FETCH.
- Latency: with ack in the first FETCH cycle, one instruction takes 4 cycles (FETCH, DECODE, EXEC, WB).
  - Throughput is 1 instruction per 4 cycles.
  - Each extra wait cycle adds 1.
- alu_en and rf_we are never high at the same time. Each is high for exactly one cycle per legal instruction.
- imem_ack while imem_req=0 is ignored; ir does not change.
- start while busy is ignored.
- Outputs are registered state or decodes of state only. There is no combinational path from imem_ack to any output.

Test Plan:
- Reset, start, imem returns ADDI 0x00100093 with ack in the first cycle -> state 1,2,3,4,1 on consecutive cycles; alu_en in cycle 3, rf_we in cycle 4; pc 0->4; retire_cnt=1; imem_addr=0 on the first fetch.
- Stream of ADD, LUI, ADDI, then ECALL, ack delayed 2 cycles each -> 6 cycles per instruction; 3 rf_we pulses; halted=1 with pc=0xC and retire_cnt=3; no rf_we for ECALL.
- Instruction 0x00000003 (load opcode) -> ERROR, illegal=1, no alu_en/rf_we. Then start -> illegal=0, pc=RESET_PC, retire_cnt=0, FETCH.
- FETCH_TIMEOUT=16 with ack never asserted -> bus_err=1 after exactly 16 FETCH cycles and imem_req=0 afterwards. Repeat with ack on the 16th cycle -> no error, DECODE.
- halt_req pulsed for 1 cycle during EXEC -> WB still asserts rf_we, pc advances, then HALT. Next start resumes fetching at the new pc.
- Async rst asserted mid-EXEC, between clock edges -> all outputs reset immediately and no rf_we pulse. PC_W=8 with pc=0xFC -> after WB pc wraps to 0x00.
